// File: rtl/cond_pkg.sv
// Shared types and the condition evaluator for the condition stage.
package cond_pkg;

  // Widest operand the evaluator accepts; operands are zero-extended to this.
  localparam int unsigned COND_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    MODE_NEVER  = 3'd0,
    MODE_EQZ    = 3'd1,
    MODE_LTZ    = 3'd2,
    MODE_LEZ    = 3'd3,
    MODE_ALWAYS = 3'd4,
    MODE_NEZ    = 3'd5,
    MODE_GEZ    = 3'd6,
    MODE_GTZ    = 3'd7
  } cond_mode_e;

  // Evaluate a sign/zero condition on the low `width` bits of `data`
  // (upper bits must be zero). Shifting left aligns the operand's sign
  // bit to the MSB without a variable bit-select.
  function automatic logic cond_eval(input cond_mode_e                mode,
                                     input logic [COND_MAX_WIDTH-1:0] data,
                                     input int unsigned               width);
    logic [COND_MAX_WIDTH-1:0] aligned;
    logic                      neg;
    logic                      zero;
    logic                      res;
    aligned = data << (COND_MAX_WIDTH - width);
    neg     = aligned[COND_MAX_WIDTH-1];
    zero    = (aligned == '0);
    res     = 1'b0;
    case (mode)
      MODE_NEVER:  res = 1'b0;
      MODE_EQZ:    res = zero;
      MODE_LTZ:    res = neg;
      MODE_LEZ:    res = neg | zero;
      MODE_ALWAYS: res = 1'b1;
      MODE_NEZ:    res = ~zero;
      MODE_GEZ:    res = ~neg;
      MODE_GTZ:    res = ~neg & ~zero;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_fifo2.sv
// Generic 2-entry FIFO with a registered input-side ready.
module cond_fifo2 #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          ready_q, ready_d;
  logic          push, pop;

  assign push      = in_valid & ready_q;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = ready_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Next occupancy/pointers; ready is derived from next occupancy so it
  // never depends combinationally on out_ready.
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
    ready_d = (occ_d != 2'd2);
  end

  // State registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: rtl/cond_gate.sv
// Condition stage: evaluates a sign/zero condition at push, buffers the
// gated result in a 2-entry FIFO and counts taken results on pop.
// WIDTH must be between 2 and COND_MAX_WIDTH.
module cond_gate
  import cond_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           in_mode,
  input  logic                 in_toggle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_taken,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic [COND_MAX_WIDTH-1:0] data_ext;
  logic                      taken;
  logic [WIDTH:0]            entry_in;
  logic [WIDTH:0]            entry_out;
  logic                      pop;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  assign data_ext = COND_MAX_WIDTH'(in_data);
  assign taken    = cond_eval(cond_mode_e'(in_mode), data_ext, WIDTH) & in_toggle;
  assign entry_in = {taken, taken ? in_data : '0};

  cond_fifo2 #(
    .DW(WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (entry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (entry_out)
  );

  assign out_taken   = entry_out[WIDTH];
  assign out_data    = entry_out[WIDTH-1:0];
  assign pop         = out_valid & out_ready;
  assign taken_count = cnt_q;

  // Saturating taken counter; clear has priority over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pop && out_taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_gate.sv
// Self-checking bench for cond_gate: directed scenarios followed by random
// traffic, compared against a queue-based behavioural model.
module tb_cond_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_mode;
  logic       in_toggle;
  logic       out_ready;
  logic       cnt_clr;

  logic        in_ready_a, out_valid_a, out_taken_a;
  logic [7:0]  out_data_a;
  logic [15:0] cnt_a;
  logic        in_ready_b, out_valid_b, out_taken_b;
  logic [7:0]  out_data_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  cond_gate #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_mode(in_mode), .in_toggle(in_toggle),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_taken(out_taken_a), .cnt_clr(cnt_clr), .taken_count(cnt_a)
  );

  cond_gate #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_mode(in_mode), .in_toggle(in_toggle),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_taken(out_taken_b), .cnt_clr(cnt_clr), .taken_count(cnt_b)
  );

  typedef struct {
    bit         taken;
    logic [7:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_ready;
  int   m_cnt_a, m_cnt_b;
  bit   last_push;
  int   n_total, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit ref_cond(input int mode, input logic [7:0] d);
    int v;
    v = int'($signed(d));
    case (mode)
      0: return 1'b0;
      1: return v == 0;
      2: return v < 0;
      3: return v <= 0;
      4: return 1'b1;
      5: return v != 0;
      6: return v >= 0;
      default: return v > 0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    bit         ev;
    logic [7:0] ed;
    bit         et;
    ev = (mq.size() != 0);
    ed = ev ? mq[0].data : 8'h00;
    et = ev ? mq[0].taken : 1'b0;
    chk({tag, "_rdy"},   32'(in_ready_a),  32'(m_ready));
    chk({tag, "_vld"},   32'(out_valid_a), 32'(ev));
    chk({tag, "_data"},  32'(out_data_a),  32'(ed));
    chk({tag, "_tkn"},   32'(out_taken_a), 32'(et));
    chk({tag, "_cnt"},   32'(cnt_a),       32'(m_cnt_a));
    chk({tag, "_data2"}, 32'(out_data_b),  32'(ed));
    chk({tag, "_cnt2"},  32'(cnt_b),       32'(m_cnt_b));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance
  // the model across the rising edge, then check at the next falling edge.
  task automatic cycle(input bit v, input logic [7:0] d, input logic [2:0] m,
                       input bit t, input bit r, input bit c);
    bit   push, pop, tk;
    ent_t e, ne;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_toggle = t;
    out_ready = r;
    cnt_clr   = c;
    push = v && m_ready;
    pop  = r && (mq.size() > 0);
    e.taken = 1'b0;
    e.data  = 8'h00;
    if (pop) e = mq.pop_front();
    if (c) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (pop && e.taken) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    if (push) begin
      tk = ref_cond(int'(m), d) && t;
      ne.taken = tk;
      ne.data  = tk ? d : 8'h00;
      mq.push_back(ne);
    end
    m_ready   = (mq.size() < 2);
    last_push = push;
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] m, input bit t, input bit r);
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, m, t, r, 1'b0);
      n++;
    end while (!last_push && n < 20);
    if (!last_push) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 3'd0, 1'b0, r, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b1;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  logic [7:0] corner [4];

  initial begin
    n_total = 0;
    n_pass  = 0;
    corner[0] = 8'h00; corner[1] = 8'h80; corner[2] = 8'h7f; corner[3] = 8'hff;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = '0; in_toggle = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(in_ready_a), 32'd1);
    chk("rst_vld", 32'(out_valid_a), 32'd0);
    chk("rst_data", 32'(out_data_a), 32'd0);
    chk("rst_tkn", 32'(out_taken_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    rst = 1'b1;

    // Positive operand, mode >0, taken; counter bumps at the pop edge.
    send(8'h05, 3'd7, 1'b1, 1'b1);
    chk("t1_vld", 32'(out_valid_a), 32'd1);
    chk("t1_data", 32'(out_data_a), 32'h05);
    chk("t1_tkn", 32'(out_taken_a), 32'd1);
    idle(1, 1'b1);
    chk("t1_cnt", 32'(cnt_a), 32'd1);

    // 0x80 is negative: mode 7 not taken, mode 2 taken.
    send(8'h80, 3'd7, 1'b1, 1'b0);
    send(8'h80, 3'd2, 1'b1, 1'b0);
    chk("t2_data0", 32'(out_data_a), 32'd0);
    chk("t2_tkn0", 32'(out_taken_a), 32'd0);
    idle(1, 1'b1);
    chk("t2_data1", 32'(out_data_a), 32'h80);
    chk("t2_tkn1", 32'(out_taken_a), 32'd1);
    chk("t2_cnt1", 32'(cnt_a), 32'd1);
    idle(1, 1'b1);
    chk("t2_cnt2", 32'(cnt_a), 32'd2);

    // Back-pressure: third push held off until a slot frees; order kept.
    send(8'h11, 3'd4, 1'b1, 1'b0);
    send(8'h22, 3'd4, 1'b1, 1'b0);
    chk("t3_full", 32'(in_ready_a), 32'd0);
    cycle(1'b1, 8'h33, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("t3_held", 32'(last_push), 32'd0);
    send(8'h33, 3'd4, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Zero operand with toggle clear is never taken.
    send(8'h00, 3'd1, 1'b0, 1'b1);
    chk("t4_tkn", 32'(out_taken_a), 32'd0);
    chk("t4_data", 32'(out_data_a), 32'd0);
    idle(2, 1'b1);

    // Saturation of the narrow counter, then clear beating an increment.
    for (int i = 0; i < 5; i++) send(8'h01, 3'd4, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t5_sat", 32'(cnt_b), 32'd3);
    send(8'h01, 3'd4, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_a", 32'(cnt_a), 32'd0);
    chk("t5_clr_b", 32'(cnt_b), 32'd0);

    // Asynchronous reset with two entries buffered.
    send(8'h01, 3'd4, 1'b1, 1'b1);
    idle(1, 1'b1);
    send(8'h44, 3'd6, 1'b1, 1'b0);
    send(8'h55, 3'd6, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_vld", 32'(out_valid_a), 32'd0);
    chk("t6_data", 32'(out_data_a), 32'd0);
    chk("t6_cnt", 32'(cnt_a), 32'd0);
    chk("t6_rdy", 32'(in_ready_a), 32'd1);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_outputs("t6_post");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 8'($urandom);
      cycle($urandom_range(3) != 0, d, 3'($urandom), $urandom_range(3) != 0,
            $urandom_range(2) != 0, $urandom_range(31) == 0);
    end
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
